// File: rtl/div_ratio_ctrl_pkg.sv
// Shared constants, FSM encoding and tick mask helper for the ADPLL divide-ratio controller.
package div_ratio_ctrl_pkg;

    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_MAX = 3'd7;

    localparam logic [1:0] SEL_DIV1 = 2'd0;
    localparam logic [1:0] SEL_DIV2 = 2'd1;
    localparam logic [1:0] SEL_DIV4 = 2'd2;
    localparam logic [1:0] SEL_DIV8 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_ALIGN = 2'd1,
        ST_SETTLE     = 2'd2
    } state_e;

    // Low sel bits of the phase that must all be set for a tick: (1<<sel)-1.
    function automatic logic [PHASE_W-1:0] sel_mask(input logic [1:0] sel);
        logic [PHASE_W:0] m;
        m = (4'd1 << sel) - 4'd1;
        return m[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/div_phase_gen.sv
// Free-running 3-bit phase counter with tick decode at the selected ratio.
// Counter clears and holds at 0 while disabled; tick is combinational from registers.
module div_phase_gen
    import div_ratio_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enable_i,
    input  logic [1:0]         sel_i,
    output logic [PHASE_W-1:0] cnt_o,
    output logic               tick_o
);

    logic [PHASE_W-1:0] cnt_q;
    logic [PHASE_W-1:0] cnt_d;
    logic [PHASE_W-1:0] mask;

    always_comb begin
        cnt_d = '0;
        if (enable_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mask   = sel_mask(sel_i);
    assign cnt_o  = cnt_q;
    assign tick_o = enable_i & ((cnt_q & mask) == mask);

endmodule

// File: rtl/div_ratio_ctrl.sv
// ADPLL divide-ratio scheduler: req/ack ratio changes committed only at the /8 boundary.
// Commit 1..8 cycles after request, ack SETTLE_CYCLES later; requests while busy are dropped.
module div_ratio_ctrl
    import div_ratio_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SEL_RESET     = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enable_i,
    input  logic               req_i,
    input  logic [1:0]         req_sel_i,
    output logic               ack_o,
    output logic               busy_o,
    output logic [1:0]         sel_o,
    output logic               tick_o,
    output logic [PHASE_W-1:0] phase_o
);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] pend_q, pend_d;
    logic [3:0] settle_q, settle_d;
    logic       ack_q, ack_d;
    logic       commit;

    div_phase_gen u_phase (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .sel_i     (sel_q),
        .cnt_o     (phase_o),
        .tick_o    (tick_o)
    );

    // A frozen counter is already aligned, so disabling forces the commit.
    assign commit = !enable_i || (phase_o == PHASE_MAX);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        settle_d = settle_q;
        ack_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (req_sel_i == sel_q) begin
                        ack_d = 1'b1;
                    end else begin
                        pend_d  = req_sel_i;
                        state_d = ST_WAIT_ALIGN;
                    end
                end
            end
            ST_WAIT_ALIGN: begin
                if (commit) begin
                    sel_d    = pend_q;
                    settle_d = 4'(SETTLE_CYCLES - 1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'(SEL_RESET);
            pend_q   <= '0;
            settle_q <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            settle_q <= settle_d;
            ack_q    <= ack_d;
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = (state_q != ST_IDLE);
    assign sel_o  = sel_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Bench for div_ratio_ctrl: directed scenarios plus random traffic against a cycle reference model.
module tb_div_ratio_ctrl;

    localparam int SETTLE = 4;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       enable_i;
    logic       req_i;
    logic [1:0] req_sel_i;
    logic       ack_o;
    logic       busy_o;
    logic [1:0] sel_o;
    logic       tick_o;
    logic [2:0] phase_o;

    int n_chk = 0;
    int n_bad = 0;
    int ack_seen = 0;

    // Reference model: phase as an integer, plus "waiting for alignment" and
    // "cycles remaining until ack" instead of an explicit state machine.
    int m_cnt, m_sel, m_pend, m_left;
    bit m_wait, m_ack;

    always #5 clk_i = ~clk_i;

    div_ratio_ctrl #(.SETTLE_CYCLES(SETTLE), .SEL_RESET(0)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .req_i     (req_i),
        .req_sel_i (req_sel_i),
        .ack_o     (ack_o),
        .busy_o    (busy_o),
        .sel_o     (sel_o),
        .tick_o    (tick_o),
        .phase_o   (phase_o)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sel  = 0;
        m_pend = 0;
        m_left = 0;
        m_wait = 0;
        m_ack  = 0;
    endtask

    task automatic model_edge();
        bit nxt_ack;
        nxt_ack = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) nxt_ack = 1;
        end else if (m_wait) begin
            if (!enable_i || m_cnt == 7) begin
                m_sel  = m_pend;
                m_wait = 0;
                m_left = SETTLE;
            end
        end else if (req_i) begin
            if (int'(req_sel_i) == m_sel) begin
                nxt_ack = 1;
            end else begin
                m_wait = 1;
                m_pend = int'(req_sel_i);
            end
        end
        m_cnt = enable_i ? (m_cnt + 1) % 8 : 0;
        m_ack = nxt_ack;
    endtask

    task automatic check_outs();
        int exp_tick;
        exp_tick = (enable_i && ((m_cnt + 1) % (1 << m_sel) == 0)) ? 1 : 0;
        chk("sel",   int'(sel_o),   m_sel);
        chk("busy",  int'(busy_o),  (m_wait || m_left > 0) ? 1 : 0);
        chk("ack",   int'(ack_o),   int'(m_ack));
        chk("phase", int'(phase_o), m_cnt);
        chk("tick",  int'(tick_o),  exp_tick);
    endtask

    task automatic step(input bit e, input bit r, input int s);
        enable_i  = e;
        req_i     = r;
        req_sel_i = s[1:0];
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        req_i = 1'b0;
        check_outs();
        if (ack_o) ack_seen++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0);
    endtask

    task automatic align_cnt(input int c);
        for (int k = 0; k < 8 && m_cnt != c; k++) step(1, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (m_wait || m_left > 0); k++) step(1, 0, 0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        enable_i  = 1'b1;
        req_i     = 1'b0;
        req_sel_i = 2'd0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_outs();
        reset_n_i = 1'b1;

        // /1 after reset: tick every cycle
        idle(16);

        // /1 -> /8 requested at phase 2
        align_cnt(2);
        step(1, 1, 3);
        idle(24);

        // /8 -> /2, then a same-ratio request that acks immediately
        drain();
        step(1, 1, 1);
        idle(16);
        ack_seen = 0;
        step(1, 1, 1);
        idle(4);
        chk("same_ack", ack_seen, 1);

        // /2 -> /8 -> /4 with a second request dropped during settle
        step(1, 1, 3);
        drain();
        ack_seen = 0;
        step(1, 1, 2);
        for (int k = 0; k < 12 && m_left == 0; k++) step(1, 0, 0);
        step(1, 1, 0);
        idle(12);
        chk("dbl_ack", ack_seen, 1);
        chk("dbl_sel", int'(sel_o), 2);

        // /4 -> /1 with enable dropped while waiting at phase 4
        align_cnt(1);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0);
        idle(10);

        // Async reset in the middle of SETTLE aborts the request
        step(1, 1, 3);
        for (int k = 0; k < 12 && m_left == 0; k++) step(1, 0, 0);
        step(1, 0, 0);
        #2 reset_n_i = 1'b0;
        #1;
        model_reset();
        check_outs();
        #1 reset_n_i = 1'b1;
        ack_seen = 0;
        idle(20);
        chk("rst_noack", ack_seen, 0);
        chk("rst_sel", int'(sel_o), 0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
